// File: rtl/timer_measure_arbiter.sv
// ---------------------------------------------------------------------------
// timer_measure_arbiter
//
// Shares one capture Timer between NUM_REQ requesters. A round-robin arbiter
// hands out exclusive ownership, then a small FSM sequences the Timer:
// enable -> run until stop/abandon -> capture gate -> latch result -> release.
// The result is tagged with the owner's index and held until the next done.
//
// Optional feature: define TIMER_ARB_TIMEOUT_EN to add a RUN-phase timeout
// (TMO_CYC cycles) that forces a capture and flags result_tmo. Without it,
// RUN waits indefinitely and result_tmo is tied to 0.
//
// Ports
//   S_AXI_ACLK        clock
//   AXI_RESET         synchronous reset, active high
//   req[N]            level, requester wants a measurement
//   stop[N]           1-cycle pulse, end of interval (only the owner's counts)
//   ovf_en[N]         per-requester overflow enable
//   grant[N]          one-hot owner (or zero)
//   done              1-cycle pulse, result fields valid
//   result            captured 32-bit count
//   result_ovf        Timer overflow flag sampled at capture
//   result_tmo        measurement ended by timeout
//   result_id         owner index of the result
//   busy              FSM not idle
//   timer_enable      to Timer
//   capture_gate      to Timer
//   overflow_enable   to Timer, owner's ovf_en while granted
//   capture_complete  from Timer
//   overflow_flag     from Timer
//   cap_timer_out     from Timer
// ---------------------------------------------------------------------------
module timer_measure_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          ID_W    = 2,
  parameter logic [31:0] TMO_CYC = 32'hFFFF_FFF0
) (
  input  logic               S_AXI_ACLK,
  input  logic               AXI_RESET,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] stop,
  input  logic [NUM_REQ-1:0] ovf_en,
  output logic [NUM_REQ-1:0] grant,
  output logic               done,
  output logic [31:0]        result,
  output logic               result_ovf,
  output logic               result_tmo,
  output logic [ID_W-1:0]    result_id,
  output logic               busy,
  output logic               timer_enable,
  output logic               capture_gate,
  output logic               overflow_enable,
  input  logic               capture_complete,
  input  logic               overflow_flag,
  input  logic [31:0]        cap_timer_out
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_CAPT, S_REL} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]    r_owner, w_owner_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt;
  logic               r_en, w_en_nxt;
  logic               r_gate, w_gate_nxt;
  logic               r_done, w_done_nxt;
  logic [31:0]        r_result, w_result_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_tmo, w_tmo_nxt;
  logic               r_tmo_pend, w_tmo_pend_nxt;
  logic               r_rel, w_rel_nxt;

  logic               w_pick_vld;
  logic [ID_W-1:0]    w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_oh;
  int                 w_dist, w_best;
  logic               w_stop_own, w_req_own, w_tmo, w_end_run;

  // Round-robin pick: the set req bit with the smallest distance from r_ptr
  // (wrapping) wins, so the previous owner goes to the back of the queue.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_best     = NUM_REQ;
    w_dist     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
      if (req[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick_vld = 1'b1;
        w_pick_idx = ID_W'(j);
      end
    end
  end

  assign w_pick_oh  = NUM_REQ'(1) << w_pick_idx;

  // Owner-relative views; stops from non-owners are masked out here.
  assign w_stop_own = |(r_grant & stop);
  assign w_req_own  = |(r_grant & req);
  assign w_end_run  = w_stop_own | ~w_req_own | w_tmo;

`ifdef TIMER_ARB_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  // Cleared while arming so it counts RUN cycles only.
  always_ff @(posedge S_AXI_ACLK) begin
    if (AXI_RESET)              r_tmo_cnt <= '0;
    else if (r_state == S_ARM)  r_tmo_cnt <= '0;
    else if (r_state == S_RUN)  r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_tmo      = (r_state == S_RUN) && (r_tmo_cnt == TMO_CYC - 32'd1);
  assign result_tmo = r_tmo;
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign result_tmo   = 1'b0;
  assign w_unused_tmo = ^{TMO_CYC, r_tmo};
`endif

  // State register plus registered outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (AXI_RESET) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_id       <= '0;
      r_en       <= 1'b0;
      r_gate     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
      r_tmo_pend <= 1'b0;
      r_rel      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_id       <= w_id_nxt;
      r_en       <= w_en_nxt;
      r_gate     <= w_gate_nxt;
      r_done     <= w_done_nxt;
      r_result   <= w_result_nxt;
      r_ovf      <= w_ovf_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tmo_pend <= w_tmo_pend_nxt;
      r_rel      <= w_rel_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld)       w_state_nxt = S_ARM;
      S_ARM:                         w_state_nxt = S_RUN;
      S_RUN:   if (w_end_run)        w_state_nxt = S_CAPT;
      S_CAPT:  if (capture_complete) w_state_nxt = S_REL;
      S_REL:   if (r_rel)            w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_id_nxt       = r_id;
    w_en_nxt       = r_en;
    w_gate_nxt     = r_gate;
    w_done_nxt     = 1'b0;
    w_result_nxt   = r_result;
    w_ovf_nxt      = r_ovf;
    w_tmo_nxt      = r_tmo;
    w_tmo_pend_nxt = r_tmo_pend;
    w_rel_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_oh;
          w_owner_nxt = w_pick_idx;
        end
      end
      S_ARM: w_en_nxt = 1'b1;
      S_RUN: begin
        if (w_end_run) begin
          w_gate_nxt     = 1'b1;
          // A real stop or abandon on the same cycle takes precedence.
          w_tmo_pend_nxt = w_tmo & ~w_stop_own & w_req_own;
        end
      end
      S_CAPT: begin
        if (capture_complete) begin
          w_result_nxt = cap_timer_out;
          w_ovf_nxt    = overflow_flag;
          w_tmo_nxt    = r_tmo_pend;
          w_id_nxt     = r_owner;
          w_done_nxt   = 1'b1;
        end
      end
      S_REL: begin
        // Two-cycle release: first cycle drops the Timer controls, second
        // gives the Timer time to walk WAIT->IDLE and clear its count.
        if (!r_rel) begin
          w_en_nxt    = 1'b0;
          w_gate_nxt  = 1'b0;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
          w_rel_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant           = r_grant;
  assign done            = r_done;
  assign result          = r_result;
  assign result_ovf      = r_ovf;
  assign result_id       = r_id;
  assign busy            = (r_state != S_IDLE);
  assign timer_enable    = r_en;
  assign capture_gate    = r_gate;
  assign overflow_enable = |(r_grant & ovf_en);

endmodule
